// File: rtl/sync_debounce.sv
// sync_debounce
//   Multi-channel synchronizer and debounce filter for asynchronous level
//   inputs. Each channel runs through a STAGES-deep flop chain, then a
//   per-channel counter that only lets q follow the synchronized value once
//   it has differed from q for DEBOUNCE_CYCLES consecutive edges.
//
// Ports
//   clk    clock
//   rst    synchronous, active-high reset
//   d      [WIDTH] asynchronous channel inputs
//   q      [WIDTH] synchronized, debounced levels
//   rise   [WIDTH] one-cycle strobe on a q 0->1 transition
//   fall   [WIDTH] one-cycle strobe on a q 1->0 transition
//   ready  high once the post-reset flush interval has elapsed; strobes are
//          suppressed while it is low
module sync_debounce #(
  parameter int               WIDTH           = 1,
  parameter int               STAGES          = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             ready
);

  localparam int CW    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int FLUSH = STAGES + DEBOUNCE_CYCLES;
  localparam int FW    = $clog2(FLUSH) + 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_MAX = FW'(FLUSH - 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_debounce: STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("sync_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]             s;
  logic [WIDTH-1:0]             q_q, q_d;
  logic [WIDTH-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]             rise_q, rise_d;
  logic [WIDTH-1:0]             fall_q, fall_d;
  logic [FW-1:0]                flush_q, flush_d;
  logic                         ready_q, ready_d;

  assign s = sync_q[STAGES-1];

  // Synchronizer chain: plain shift, no logic between stages.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Per-channel debounce: q only follows s after CNT_MAX+1 consecutive
  // mismatching edges; any agreement in between restarts the count.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == q_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        q_d[i]   = s[i];
        cnt_d[i] = '0;
        // Strobes are gated by the current ready so a change landing on the
        // same edge that ready rises is still treated as flush activity.
        if (ready_q) begin
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end else begin
          rise_d[i] = 1'b0;
          fall_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Flush counter: ready goes high on the FLUSH-th edge after reset release
  // and then sticks; the counter freezes once ready is set.
  always_comb begin
    flush_d = flush_q;
    ready_d = ready_q;
    if (ready_q) begin
      ready_d = 1'b1;
    end else if (flush_q == FLUSH_MAX) begin
      ready_d = 1'b1;
    end else begin
      flush_d = flush_q + FW'(1);
    end
  end

  // State registers; reset overrides everything, including a partial count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {STAGES{RESET_VAL}};
      q_q     <= RESET_VAL;
      cnt_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      flush_q <= '0;
      ready_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      flush_q <= flush_d;
      ready_q <= ready_d;
    end
  end

  assign q     = q_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce
//   Directed bench for sync_debounce. Four instances cover the default
//   configuration, the DEBOUNCE_CYCLES=1 / STAGES=3 boundary, a RESET_VAL=1
//   channel and a 4-channel build. Expected values are hand-derived edge by
//   edge: a change driven before edge 1 reaches q after edge STAGES+DEBOUNCE.
module tb_sync_debounce;

  logic clk;

  // Instance A: defaults
  logic       rst_a, d_a, q_a, rise_a, fall_a, ready_a;
  // Instance B: STAGES=3, DEBOUNCE_CYCLES=1
  logic       rst_b, d_b, q_b, rise_b, fall_b, ready_b;
  // Instance C: RESET_VAL=1
  logic       rst_c, d_c, q_c, rise_c, fall_c, ready_c;
  // Instance D: WIDTH=4
  logic       rst_d, ready_d;
  logic [3:0] d_d, q_d, rise_d, fall_d;

  int n_tests;
  int n_fail;

  sync_debounce u_a (
    .clk(clk), .rst(rst_a), .d(d_a), .q(q_a),
    .rise(rise_a), .fall(fall_a), .ready(ready_a)
  );

  sync_debounce #(.STAGES(3), .DEBOUNCE_CYCLES(1)) u_b (
    .clk(clk), .rst(rst_b), .d(d_b), .q(q_b),
    .rise(rise_b), .fall(fall_b), .ready(ready_b)
  );

  sync_debounce #(.RESET_VAL(1'b1)) u_c (
    .clk(clk), .rst(rst_c), .d(d_c), .q(q_c),
    .rise(rise_c), .fall(fall_c), .ready(ready_c)
  );

  sync_debounce #(.WIDTH(4)) u_d (
    .clk(clk), .rst(rst_d), .d(d_d), .q(q_d),
    .rise(rise_d), .fall(fall_d), .ready(ready_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle, so outputs are sampled away
  // from the edge and new inputs are set up for the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    d_a = 1'b0; d_b = 1'b0; d_c = 1'b0; d_d = 4'b0000;

    // ---- 1. reset / ready on defaults ----
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("rst_q_%0d", e), q_a, 1'b0);
      check($sformatf("rst_strobe_%0d", e), {rise_a, fall_a}, 2'b00);
      check($sformatf("rst_ready_%0d", e), ready_a, 1'b0);
    end
    rst_a = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("flush_ready_e%0d", e), ready_a, (e >= 6) ? 1'b1 : 1'b0);
      check($sformatf("flush_q_e%0d", e), q_a, 1'b0);
      check($sformatf("flush_strobe_e%0d", e), {rise_a, fall_a}, 2'b00);
    end

    // ---- 2. clean rise then clean fall ----
    d_a = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("rise_q_e%0d", e), q_a, (e >= 6) ? 1'b1 : 1'b0);
      check($sformatf("rise_strobe_e%0d", e), rise_a, (e == 6) ? 1'b1 : 1'b0);
      check($sformatf("rise_nofall_e%0d", e), fall_a, 1'b0);
    end
    d_a = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("fall_q_e%0d", e), q_a, (e >= 6) ? 1'b0 : 1'b1);
      check($sformatf("fall_strobe_e%0d", e), fall_a, (e == 6) ? 1'b1 : 1'b0);
      check($sformatf("fall_norise_e%0d", e), rise_a, 1'b0);
    end

    // ---- 3. glitch rejection: 3 cycles rejected, 4 cycles accepted ----
    d_a = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) d_a = 1'b0;
      tick();
      check($sformatf("glitch3_q_e%0d", e), q_a, 1'b0);
      check($sformatf("glitch3_strobe_e%0d", e), {rise_a, fall_a}, 2'b00);
    end
    check("glitch3_cnt", 32'(u_a.cnt_q[0]), 32'd0);
    d_a = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      if (e == 5) d_a = 1'b0;
      tick();
      check($sformatf("glitch4_q_e%0d", e), q_a, (e >= 6 && e < 10) ? 1'b1 : 1'b0);
      check($sformatf("glitch4_rise_e%0d", e), rise_a, (e == 6) ? 1'b1 : 1'b0);
      check($sformatf("glitch4_fall_e%0d", e), fall_a, (e == 10) ? 1'b1 : 1'b0);
    end

    // ---- 4. DEBOUNCE_CYCLES=1, STAGES=3: one-cycle pulse passes ----
    tick();
    rst_b = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("b_ready_e%0d", e), ready_b, (e >= 4) ? 1'b1 : 1'b0);
    end
    tick();
    for (int e = 1; e <= 7; e++) begin
      d_b = (e == 1) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("b_q_e%0d", e), q_b, (e == 4) ? 1'b1 : 1'b0);
      check($sformatf("b_rise_e%0d", e), rise_b, (e == 4) ? 1'b1 : 1'b0);
      check($sformatf("b_fall_e%0d", e), fall_b, (e == 5) ? 1'b1 : 1'b0);
    end

    // ---- 5. RESET_VAL=1 with d=0: q falls, fall strobe masked ----
    d_c = 1'b0;
    tick();
    check("c_rst_q", q_c, 1'b1);
    rst_c = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("c_q_e%0d", e), q_c, (e >= 6) ? 1'b0 : 1'b1);
      check($sformatf("c_strobe_e%0d", e), {rise_c, fall_c}, 2'b00);
      check($sformatf("c_ready_e%0d", e), ready_c, (e >= 6) ? 1'b1 : 1'b0);
    end

    // ---- 6. four channels, then reset mid-count ----
    rst_d = 1'b0;
    for (int e = 1; e <= 7; e++) tick();
    check("d_ready", ready_d, 1'b1);
    d_d = 4'b0101;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("d_q_e%0d", e), q_d, (e >= 6) ? 4'b0101 : 4'b0000);
      check($sformatf("d_rise_e%0d", e), rise_d, (e == 6) ? 4'b0101 : 4'b0000);
      check($sformatf("d_fall_e%0d", e), fall_d, 4'b0000);
    end
    d_d = 4'b1101;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("d_mid_q_e%0d", e), q_d, 4'b0101);
      check($sformatf("d_mid_strobe_e%0d", e), {rise_d, fall_d}, 8'h00);
    end
    check("d_mid_cnt3", 32'(u_d.cnt_q[3]), 32'd2);
    rst_d = 1'b1;
    tick();
    check("d_rst_q", q_d, 4'b0000);
    check("d_rst_cnt3", 32'(u_d.cnt_q[3]), 32'd0);
    check("d_rst_ready", ready_d, 1'b0);
    check("d_rst_strobe", {rise_d, fall_d}, 8'h00);
    rst_d = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("d_post_q_e%0d", e), q_d, (e >= 6) ? 4'b1101 : 4'b0000);
      check($sformatf("d_post_strobe_e%0d", e), {rise_d, fall_d}, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
